// File: rtl/ioctl_load_sequencer.sv
// ioctl download sequencer: ROM byte buffer, mod/DIP latches, core reset.
// Optional LOAD_CHECKSUM_EN adds rom_sum / rom_count outputs.
module ioctl_load_sequencer #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int ROM_AW        = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              rom_wr_req,
  input  logic              rom_wr_ack,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [7:0]        mod,
  output logic [7:0]        sw0,
  output logic [7:0]        sw1,
  output logic [7:0]        sw2,
  output logic [7:0]        sw3,
  output logic [7:0]        sw4,
  output logic [7:0]        sw5,
  output logic [7:0]        sw6,
  output logic [7:0]        sw7,
  output logic              core_reset,
  output logic              load_busy,
  output logic              wr_overflow
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [7:0]        rom_sum,
  output logic [16:0]       rom_count
`endif
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_req;
  logic [ROM_AW-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_ovf;
  logic [7:0]        r_mod;
  logic [7:0]        r_sw [8];

  logic w_in_range;
  logic w_rom_hit;
  logic w_free;
  logic w_load;
  logic w_req_nxt;

  assign w_in_range = (ioctl_addr >> ROM_AW) == 25'd0;
  assign w_rom_hit  = ioctl_wr && (ioctl_index == 8'd0) &&
                      w_in_range && (r_state == S_LOAD);
  // An ack in the same cycle frees the slot for a back-to-back byte.
  assign w_free     = !r_req || rom_wr_ack;
  assign w_load     = w_rom_hit && w_free;
  assign w_req_nxt  = w_load || (r_req && !rom_wr_ack);

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_SETTLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; LOAD exit looks at the post-edge buffer state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_SETTLE;
      S_LOAD: begin
        if (!ioctl_download)
          w_state_nxt = w_req_nxt ? S_DRAIN : S_SETTLE;
      end
      S_DRAIN: begin
        if (ioctl_download) w_state_nxt = S_LOAD;
        else if (!w_req_nxt) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (ioctl_download) w_state_nxt = S_LOAD;
        else if (r_cnt == LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (ioctl_download) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_SETTLE;
    endcase
  end

  // Settle counter: runs only while staying in SETTLE, zero otherwise.
  always_ff @(posedge clk_sys) begin
    if (reset)
      r_cnt <= '0;
    else if (r_state == S_SETTLE && w_state_nxt == S_SETTLE)
      r_cnt <= r_cnt + 1'b1;
    else
      r_cnt <= '0;
  end

  // One-entry ROM write buffer with sticky overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_data <= 8'h00;
      r_ovf  <= 1'b0;
    end else begin
      if (w_load) begin
        r_req  <= 1'b1;
        r_addr <= ioctl_addr[ROM_AW-1:0];
        r_data <= ioctl_dout;
      end else if (rom_wr_ack) begin
        r_req <= 1'b0;
      end
      if (w_rom_hit && !w_free) r_ovf <= 1'b1;
    end
  end

  // Machine-select and DIP bank latches, honoured in any state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_mod <= 8'h00;
      for (int i = 0; i < 8; i++) r_sw[i] <= 8'h00;
    end else if (ioctl_wr) begin
      if (ioctl_index == 8'd1) r_mod <= ioctl_dout;
      if (ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0)
        r_sw[ioctl_addr[2:0]] <= ioctl_dout;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [7:0]  r_sum;
  logic [16:0] r_count;

  // Running sum/count of acked ROM bytes, cleared on each new load.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sum   <= 8'h00;
      r_count <= 17'd0;
    end else if (w_state_nxt == S_LOAD && r_state != S_LOAD) begin
      r_sum   <= 8'h00;
      r_count <= 17'd0;
    end else if (r_req && rom_wr_ack) begin
      r_sum   <= r_sum + r_data;
      r_count <= r_count + 17'd1;
    end
  end

  assign rom_sum   = r_sum;
  assign rom_count = r_count;
`endif

  assign rom_wr_req  = r_req;
  assign rom_addr    = r_addr;
  assign rom_data    = r_data;
  assign wr_overflow = r_ovf;
  assign mod         = r_mod;
  assign sw0         = r_sw[0];
  assign sw1         = r_sw[1];
  assign sw2         = r_sw[2];
  assign sw3         = r_sw[3];
  assign sw4         = r_sw[4];
  assign sw5         = r_sw[5];
  assign sw6         = r_sw[6];
  assign sw7         = r_sw[7];
  assign core_reset  = (r_state != S_RUN);
  assign load_busy   = (r_state == S_LOAD) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_ioctl_load_sequencer.sv
// Bench for ioctl_load_sequencer: directed cases plus random traffic
// checked every cycle against a behavioural model.
module tb_ioctl_load_sequencer;

  localparam int N  = 32;
  localparam int AW = 16;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic [7:0]    ioctl_index = '0;
  logic          rom_wr_req;
  logic          rom_wr_ack = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    mod;
  logic [7:0]    sw0, sw1, sw2, sw3, sw4, sw5, sw6, sw7;
  logic          core_reset;
  logic          load_busy;
  logic          wr_overflow;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]    rom_sum;
  logic [16:0]   rom_count;
`endif

  ioctl_load_sequencer #(.SETTLE_CYCLES(N), .ROM_AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index),
    .rom_wr_req(rom_wr_req), .rom_wr_ack(rom_wr_ack),
    .rom_addr(rom_addr), .rom_data(rom_data), .mod(mod),
    .sw0(sw0), .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .sw4(sw4), .sw5(sw5), .sw6(sw6), .sw7(sw7),
    .core_reset(core_reset), .load_busy(load_busy),
    .wr_overflow(wr_overflow)
`ifdef LOAD_CHECKSUM_EN
    , .rom_sum(rom_sum), .rom_count(rom_count)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] sw_o [8];
  assign sw_o[0] = sw0;
  assign sw_o[1] = sw1;
  assign sw_o[2] = sw2;
  assign sw_o[3] = sw3;
  assign sw_o[4] = sw4;
  assign sw_o[5] = sw5;
  assign sw_o[6] = sw6;
  assign sw_o[7] = sw7;

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_LOAD, P_DRAIN, P_SETTLE, P_RUN} ph_t;
  ph_t         m_ph;
  int          m_wait;
  bit          m_pend;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  bit          m_ovf;
  logic [7:0]  m_mod;
  logic [7:0]  m_sw [8];
  int          m_sum;
  int          m_nb;
  bit          acc;
  bit          ackd;
  bit          to_load;

  always @(posedge clk_sys) begin
    if (reset) begin
      m_ph = P_SETTLE; m_wait = 0; m_pend = 0;
      m_addr = 0; m_data = 0; m_ovf = 0; m_mod = 0;
      for (int i = 0; i < 8; i++) m_sw[i] = 0;
      m_sum = 0; m_nb = 0;
    end else begin
      ackd = rom_wr_ack && m_pend;
      acc  = ioctl_wr && ioctl_index == 0 && m_ph == P_LOAD &&
             ioctl_addr < (25'd1 << AW);
      if (ackd) begin
        m_sum = (m_sum + m_data) % 256;
        m_nb++;
        m_pend = 0;
      end
      if (acc) begin
        if (m_pend) m_ovf = 1;
        else begin
          m_pend = 1; m_addr = ioctl_addr[15:0]; m_data = ioctl_dout;
        end
      end
      if (ioctl_wr && ioctl_index == 1) m_mod = ioctl_dout;
      if (ioctl_wr && ioctl_index == 254 && ioctl_addr < 8)
        m_sw[ioctl_addr[2:0]] = ioctl_dout;
      to_load = 0;
      case (m_ph)
        P_RUN: if (ioctl_download) to_load = 1;
        P_LOAD: if (!ioctl_download) begin
          m_ph = m_pend ? P_DRAIN : P_SETTLE;
          m_wait = 0;
        end
        P_DRAIN:
          if (ioctl_download) to_load = 1;
          else if (!m_pend) begin m_ph = P_SETTLE; m_wait = 0; end
        default:
          if (ioctl_download) to_load = 1;
          else if (m_wait == N - 1) m_ph = P_RUN;
          else m_wait++;
      endcase
      if (to_load) begin
        m_ph = P_LOAD; m_sum = 0; m_nb = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("rom_wr_req", rom_wr_req, m_pend);
      chk("rom_addr", rom_addr, m_addr);
      chk("rom_data", rom_data, m_data);
      chk("wr_overflow", wr_overflow, m_ovf);
      chk("mod", mod, m_mod);
      for (int i = 0; i < 8; i++) chk("sw", sw_o[i], m_sw[i]);
      chk("core_reset", core_reset, m_ph != P_RUN);
      chk("load_busy", load_busy, m_ph == P_LOAD || m_ph == P_DRAIN);
`ifdef LOAD_CHECKSUM_EN
      chk("rom_sum", rom_sum, m_sum);
      chk("rom_count", rom_count, m_nb);
`endif
    end
  end

  // ---------------- stimulus ----------------
  int ack_mode = 3;   // 1: ack every req, 2: random, 3: manual
  bit cap_en = 0;
  logic [23:0] cap_q [$];

  always @(posedge clk_sys)
    if (cap_en && rom_wr_req && rom_wr_ack)
      cap_q.push_back({rom_addr, rom_data});

  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
    if (ack_mode == 1) rom_wr_ack = rom_wr_req;
    else if (ack_mode == 2) rom_wr_ack = ($urandom_range(0, 2) == 0);
  endtask

  task automatic wr(logic [7:0] idx, logic [24:0] a, logic [7:0] d);
    ioctl_wr = 1; ioctl_index = idx; ioctl_addr = a; ioctl_dout = d;
  endtask

  task automatic settle_out();
    ioctl_download = 0; ioctl_wr = 0;
    repeat (N + 6) tick();
  endtask

  logic [7:0] tbl [4];
  int n;

  initial begin
    tbl[0] = 8'hA5; tbl[1] = 8'h5A; tbl[2] = 8'hFF; tbl[3] = 8'h01;
    tick();
    chk_en = 1;
    tick(); tick();
    reset = 0;
    // core_reset must stay high for exactly N cycles
    n = 0;
    while (core_reset && n < 200) begin n++; tick(); end
    chk("settle_len", n, N);
    chk("mod_rst", mod, 8'h00);
    chk("sw7_rst", sw7, 8'h00);

    // four ROM bytes with prompt acks
    ack_mode = 1; cap_en = 1;
    ioctl_download = 1; tick();
    for (int i = 0; i < 4; i++) begin
      wr(8'd0, 25'(i), tbl[i]); tick();
      ioctl_wr = 0; tick(); tick();
    end
    cap_en = 0;
    chk("ack_count", cap_q.size(), 4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++)
      chk("ack_byte", cap_q[i], {16'(i), tbl[i]});
    chk("ovf_clean", wr_overflow, 1'b0);
`ifdef LOAD_CHECKSUM_EN
    chk("sum4", rom_sum, 8'hFF);
    chk("count4", rom_count, 17'd4);
`endif
    settle_out();

    // overflow: two strobes, no ack
    ack_mode = 3; rom_wr_ack = 0;
    ioctl_download = 1; tick();
    wr(8'd0, 25'd10, 8'h11); tick();
    wr(8'd0, 25'd11, 8'h22); tick();
    ioctl_wr = 0; tick();
    chk("ovf_data", rom_data, 8'h11);
    chk("ovf_addr", rom_addr, 16'd10);
    chk("ovf_flag", wr_overflow, 1'b1);
    rom_wr_ack = 1; tick(); rom_wr_ack = 0; tick();

    // strobe coincident with ack
    wr(8'd0, 25'd20, 8'h33); tick();
    ioctl_wr = 0; tick();
    rom_wr_ack = 1; wr(8'd0, 25'd21, 8'h44); tick();
    chk("b2b_req", rom_wr_req, 1'b1);
    chk("b2b_addr", rom_addr, 16'd21);
    chk("b2b_data", rom_data, 8'h44);
    rom_wr_ack = 0; ioctl_wr = 0; ack_mode = 1;
    tick(); tick();
    settle_out();

    // DIP and mod bytes, outside any download
    wr(8'd254, 25'd2, 8'h3C); tick();
    wr(8'd254, 25'd9, 8'h77); tick();
    wr(8'd1, 25'd0, 8'h05); tick();
    ioctl_wr = 0; tick();
    chk("sw2", sw2, 8'h3C);
    chk("sw1", sw1, 8'h00);
    chk("mod", mod, 8'h05);

    // download ends with req pending, ack 10 cycles late
    ack_mode = 3; rom_wr_ack = 0;
    ioctl_download = 1; tick();
    wr(8'd0, 25'd5, 8'h99); tick();
    ioctl_wr = 0; ioctl_download = 0;
    repeat (10) begin tick(); chk("drain_busy", load_busy, 1'b1); end
    rom_wr_ack = 1; tick(); rom_wr_ack = 0;
    chk("drain_done", load_busy, 1'b0);
    chk("drain_rst", core_reset, 1'b1);
    repeat (N + 2) tick();
    chk("run_after", core_reset, 1'b0);

    // reset in the middle of a download
    ioctl_download = 1; tick();
    wr(8'd0, 25'd7, 8'h66); tick();
    ioctl_wr = 0; reset = 1; tick();
    chk("rst_req", rom_wr_req, 1'b0);
    chk("rst_core", core_reset, 1'b1);
    reset = 0; tick();
    chk("rst_reload", load_busy, 1'b1);
    ack_mode = 1;
    settle_out();

    // random traffic
    ack_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 3) ioctl_download = ~ioctl_download;
      reset = ($urandom_range(0, 499) == 0);
      ioctl_wr = ($urandom_range(0, 2) == 0);
      ioctl_dout = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          ioctl_index = 8'd0;
          ioctl_addr = 25'($urandom_range(0, 300));
          if ($urandom_range(0, 7) == 0) ioctl_addr = ioctl_addr + 25'h10000;
        end
        3: begin ioctl_index = 8'd1; ioctl_addr = 25'($urandom_range(0, 3)); end
        4: begin ioctl_index = 8'd254; ioctl_addr = 25'($urandom_range(0, 12)); end
        default: begin ioctl_index = 8'd7; ioctl_addr = 25'($urandom_range(0, 7)); end
      endcase
      tick();
    end
    reset = 0; ack_mode = 1;
    settle_out();
    chk("final_run", core_reset, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
